// File: rtl/async_sram_ctrl_pkg.sv
// Shared encodings for the asynchronous cellular-RAM controller:
// FSM states, chip-control vectors and their bit positions.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int CTRL_W = 7;

  // Vector order is {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}.
  localparam int CB_ADV = 6;
  localparam int CB_CLK = 5;
  localparam int CB_CS  = 4;
  localparam int CB_OE  = 3;
  localparam int CB_WR  = 2;
  localparam int CB_LB  = 1;
  localparam int CB_UB  = 0;

  localparam logic [CTRL_W-1:0] CTRL_IDLE       = 7'b1111111;
  localparam logic [CTRL_W-1:0] CTRL_READ_BASE  = 7'b0000100;
  localparam logic [CTRL_W-1:0] CTRL_WRITE_BASE = 7'b0001000;

  function automatic logic [CTRL_W-1:0] ctrl_vec(input logic [CTRL_W-1:0] base,
                                                 input logic            lb_n,
                                                 input logic            ub_n);
    logic [CTRL_W-1:0] v;
    v        = base;
    v[CB_LB] = lb_n;
    v[CB_UB] = ub_n;
    return v;
  endfunction

endpackage

// File: rtl/async_sram_ctrl_if.sv
// Request/response bundle between user logic and the SRAM controller.
// Handshake: a request transfers on any rising edge where req_valid and req_ready are both high;
// the requester holds req_* stable until then. rd_valid is a one-cycle strobe, no back-pressure.
interface async_sram_ctrl_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rd_valid, rd_data, busy
  );

endinterface

// File: rtl/async_sram_ctrl_db_pad.sv
// MemDB pad: registered output enable, tristate driver and raw input path.
module sram_db_pad #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  inout  wire  [DATA_W-1:0] db_io
);

  logic oe_q;

  // Reset releases the bus immediately, even mid-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oe_q <= 1'b0;
    else        oe_q <= oe_i;
  end

  assign db_io   = oe_q ? wdata_i : {DATA_W{1'bz}};
  assign rdata_o = db_io;

endmodule

// File: rtl/async_sram_ctrl.sv
// Single-word asynchronous-mode cellular RAM controller with byte lanes,
// fixed strobe width of WAIT_CYCLES and a one-cycle recovery slot.
module async_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 6,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  async_sram_ctrl_if.slave    req,
  output logic [ADDR_W-1:0]   MemAdr,
  inout  wire  [DATA_W-1:0]   MemDB,
  output logic                RamAdv,
  output logic                RamClk,
  output logic                RamCS,
  output logic                MemOE,
  output logic                MemWR,
  output logic                RamLB,
  output logic                RamUB,
  output state_t              dbg_state_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic                we_q;
  logic                lb_n_q, ub_n_q;
  logic                lb_n_sel, ub_n_sel;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   db_in;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                db_oe_d;
  logic                accept;
  logic                last_cyc;
  logic                capture;

  // ready_q is only ever high while in IDLE, so it alone qualifies an accept.
  assign accept   = req.req_valid & ready_q;
  assign last_cyc = (cnt_q == CNT_LAST);
  assign capture  = (state_q == READ) && last_cyc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req.req_we ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      READ, WRITE: begin
        if (last_cyc) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane 0 drives RamLB, the top lane drives RamUB.
  always_comb begin
    lb_n_sel = lb_n_q;
    ub_n_sel = ub_n_q;
    if (accept) begin
      lb_n_sel = ~req.req_be[0];
      ub_n_sel = ~req.req_be[BE_W-1];
    end
  end

  // Pin values are decided from the next state so every control leaves a flop.
  always_comb begin
    ctrl_d     = CTRL_IDLE;
    db_oe_d    = 1'b0;
    ready_d    = (state_d == IDLE);
    rd_valid_d = capture;
    case (state_d)
      READ:    ctrl_d = ctrl_vec(CTRL_READ_BASE, lb_n_sel, ub_n_sel);
      WRITE: begin
        ctrl_d  = ctrl_vec(CTRL_WRITE_BASE, lb_n_sel, ub_n_sel);
        db_oe_d = 1'b1;
      end
      RECOVER: db_oe_d = we_q;
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      ctrl_q     <= CTRL_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else if (accept) begin
      adr_q   <= req.req_addr;
      wdata_q <= req.req_wdata;
      we_q    <= req.req_we;
      lb_n_q  <= lb_n_sel;
      ub_n_q  <= ub_n_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (capture) rd_data_q <= db_in;
  end

  sram_db_pad #(
    .DATA_W (DATA_W)
  ) u_db_pad (
    .clk     (clk),
    .rst_n   (rst_n),
    .oe_i    (db_oe_d),
    .wdata_i (wdata_q),
    .rdata_o (db_in),
    .db_io   (MemDB)
  );

  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_q;
  assign MemAdr        = adr_q;
  assign req.req_ready = ready_q;
  assign req.rd_valid  = rd_valid_q;
  assign req.rd_data   = rd_data_q;
  assign req.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed bench for async_sram_ctrl: a default build against a small RAM model,
// and a WAIT_CYCLES=1 build against a constant-data responder.
module tb_async_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int W = 6;
  localparam logic [15:0] PROBE = 16'h5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- default build ----------------
  async_sram_ctrl_if #(.ADDR_W(23), .DATA_W(16)) bus ();
  logic [22:0] mem_adr;
  wire  [15:0] mem_db;
  logic ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub;
  state_t dbg_state;

  async_sram_ctrl #(.ADDR_W(23), .DATA_W(16), .WAIT_CYCLES(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus.slave),
    .MemAdr(mem_adr), .MemDB(mem_db),
    .RamAdv(ram_adv), .RamClk(ram_clk), .RamCS(ram_cs), .MemOE(mem_oe), .MemWR(mem_wr),
    .RamLB(ram_lb), .RamUB(ram_ub), .dbg_state_o(dbg_state)
  );

  logic [15:0] mem [0:63];
  logic probe_en = 1'b0;
  assign mem_db = (!ram_cs && !mem_oe) ? mem[mem_adr[5:0]] : (probe_en ? PROBE : 16'hzzzz);

  always @(negedge clk) begin
    if (!ram_cs && !mem_wr) begin
      if (!ram_lb) mem[mem_adr[5:0]][7:0]  <= mem_db[7:0];
      if (!ram_ub) mem[mem_adr[5:0]][15:8] <= mem_db[15:8];
    end
  end

  // ---------------- WAIT_CYCLES=1 build ----------------
  async_sram_ctrl_if #(.ADDR_W(23), .DATA_W(16)) bus1 ();
  logic [22:0] mem_adr1;
  wire  [15:0] mem_db1;
  logic ram_adv1, ram_clk1, ram_cs1, mem_oe1, mem_wr1, ram_lb1, ram_ub1;
  state_t dbg_state1;

  async_sram_ctrl #(.ADDR_W(23), .DATA_W(16), .WAIT_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(bus1.slave),
    .MemAdr(mem_adr1), .MemDB(mem_db1),
    .RamAdv(ram_adv1), .RamClk(ram_clk1), .RamCS(ram_cs1), .MemOE(mem_oe1), .MemWR(mem_wr1),
    .RamLB(ram_lb1), .RamUB(ram_ub1), .dbg_state_o(dbg_state1)
  );

  assign mem_db1 = (!ram_cs1 && !mem_oe1) ? 16'hBEEF : 16'hzzzz;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int cyc = 0;
  int acc_q[$];
  int rd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      rd_cnt++;
      if (exp_q.size() == 0) check_eq("rd_unexpected", 32'd1, 32'd0);
      else                   check_eq("rd_data", bus.rd_data, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  int r_cs_first, r_cs_cnt, r_wr_cnt, r_oe_cnt, r_rdv_at, r_rdv_cnt, r_hs_bad, r_lane_bad;
  logic r_rdy_end;
  logic [15:0] r_db_w, r_db_rec, r_db_idle;

  task automatic wait_ready(output logic ok);
    int waited = 0;
    while (!bus.req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    ok = bus.req_ready;
  endtask

  task automatic do_access(input logic we, input logic [22:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input logic [15:0] exp_rd);
    logic ok;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    wait_ready(ok);
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (!we) exp_q.push_back(exp_rd);
    r_cs_first = 0; r_cs_cnt = 0; r_wr_cnt = 0; r_oe_cnt = 0;
    r_rdv_at = 0; r_rdv_cnt = 0; r_hs_bad = 0; r_lane_bad = 0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (!ram_cs) begin
        if (r_cs_cnt == 0) r_cs_first = k;
        r_cs_cnt++;
        if (ram_lb != ~be[0]) r_lane_bad++;
        if (ram_ub != ~be[1]) r_lane_bad++;
      end
      if (!mem_wr) r_wr_cnt++;
      if (!mem_oe) r_oe_cnt++;
      if (bus.rd_valid) begin
        r_rdv_cnt++;
        r_rdv_at = k;
      end
      if (k <= W + 1 && (bus.req_ready || !bus.busy)) r_hs_bad++;
      if (k == 1) r_db_w = mem_db;
      if (k == W + 1) r_db_rec = mem_db;
      if (k == W + 2) begin
        r_rdy_end = bus.req_ready;
        probe_en  = 1'b1;
        #1;
        r_db_idle = mem_db;
        probe_en  = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int bad;
  int start;
  int n;
  logic ok1;
  int oe1_cnt, oe1_first, rdv1_at;
  logic [15:0] rd1_data;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_be = '0;

    // 1. reset with a request pending
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 23'h7; bus.req_wdata = 16'h1111; bus.req_be = 2'b11;
    bad = 0;
    probe_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub} != CTRL_IDLE) bad++;
      if (bus.req_ready || bus.busy || bus.rd_valid) bad++;
      if (mem_db != PROBE) bad++;
    end
    probe_en = 1'b0;
    check_eq("rst_hold", bad, 0);
    check_eq("rst_memadr", mem_adr, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    check_eq("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready_pre_edge", bus.req_ready, 0);
    @(negedge clk);
    check_eq("rst_ready_after", bus.req_ready, 1);
    check_eq("rst_no_access", bus.busy, 0);
    bus.req_valid = 1'b0;

    // 2. full write then read of the same word
    do_access(1'b1, 23'h5, 16'hA5C3, 2'b11, 16'h0);
    check_eq("wr_cs_first", r_cs_first, 1);
    check_eq("wr_strobe_len", r_cs_cnt, W);
    check_eq("wr_wr_len", r_wr_cnt, W);
    check_eq("wr_oe_len", r_oe_cnt, 0);
    check_eq("wr_db_drive", r_db_w, 16'hA5C3);
    check_eq("wr_db_hold", r_db_rec, 16'hA5C3);
    check_eq("wr_db_release", r_db_idle, PROBE);
    check_eq("wr_no_rdv", r_rdv_cnt, 0);
    check_eq("wr_handshake", r_hs_bad, 0);
    check_eq("wr_ready_end", r_rdy_end, 1);
    check_eq("wr_mem", mem[5], 16'hA5C3);

    do_access(1'b0, 23'h5, 16'h0, 2'b11, 16'hA5C3);
    check_eq("rd_oe_len", r_oe_cnt, W);
    check_eq("rd_wr_len", r_wr_cnt, 0);
    check_eq("rd_lanes", r_lane_bad, 0);
    check_eq("rd_rdv_at", r_rdv_at, W + 1);
    check_eq("rd_rdv_cnt", r_rdv_cnt, 1);
    check_eq("rd_handshake", r_hs_bad, 0);
    check_eq("rd_db_idle", r_db_idle, PROBE);

    // 3. low-lane-only write over a preloaded word
    do_access(1'b1, 23'h9, 16'hFFFF, 2'b11, 16'h0);
    do_access(1'b1, 23'h9, 16'h1234, 2'b01, 16'h0);
    check_eq("lane_ctrl", r_lane_bad, 0);
    check_eq("lane_strobe_len", r_cs_cnt, W);
    check_eq("lane_mem", mem[9], 16'hFF34);
    do_access(1'b0, 23'h9, 16'h0, 2'b11, 16'hFF34);

    // be == 0 read is still sequenced with both lanes high
    do_access(1'b0, 23'h5, 16'h0, 2'b00, 16'hA5C3);
    check_eq("be0_lanes", r_lane_bad, 0);
    check_eq("be0_strobe_len", r_cs_cnt, W);
    check_eq("be0_rdv_at", r_rdv_at, W + 1);

    // 4. back-to-back reads with req_valid held
    @(negedge clk);
    start = acc_q.size();
    repeat (3) exp_q.push_back(16'hA5C3);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 23'h5; bus.req_be = 2'b11;
    n = 0; bad = 0;
    while (acc_q.size() - start < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.busy == bus.req_ready) bad++;
    end
    bus.req_valid = 1'b0;
    check_eq("b2b_accepts", acc_q.size() - start, 3);
    if (acc_q.size() - start >= 3) begin
      check_eq("b2b_gap1", acc_q[start+1] - acc_q[start], W + 2);
      check_eq("b2b_gap2", acc_q[start+2] - acc_q[start+1], W + 2);
    end
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.busy == bus.req_ready) bad++;
    end
    check_eq("b2b_ready_busy", bad, 0);
    check_eq("b2b_drain", exp_q.size(), 0);
    check_eq("rd_total", rd_cnt, 6);
    check_eq("rd_data_hold", bus.rd_data, 16'hA5C3);

    // 5. WAIT_CYCLES = 1 build
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 23'h3; bus1.req_be = 2'b11;
    n = 0;
    while (!bus1.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok1 = bus1.req_ready;
    check_eq("w1_accept", ok1, 1);
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    oe1_cnt = 0; oe1_first = 0; rdv1_at = 0; rd1_data = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) check_eq("w1_state", dbg_state1, READ);
      if (k == 1) check_eq("w1_adr", mem_adr1, 23'h3);
      if (!mem_oe1) begin
        if (oe1_cnt == 0) oe1_first = k;
        oe1_cnt++;
      end
      if (bus1.rd_valid) begin
        rdv1_at  = k;
        rd1_data = bus1.rd_data;
      end
    end
    check_eq("w1_oe_len", oe1_cnt, 1);
    check_eq("w1_oe_first", oe1_first, 1);
    check_eq("w1_rdv_at", rdv1_at, 2);
    check_eq("w1_rd_data", rd1_data, 16'hBEEF);

    // 6. reset during the third WRITE cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 23'hC; bus.req_wdata = 16'h7777; bus.req_be = 2'b11;
    wait_ready(ok1);
    check_eq("mid_accept", ok1, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_wr_before", mem_wr, 0);
    check_eq("mid_db_before", mem_db, 16'h7777);
    rst_n = 1'b0;
    probe_en = 1'b1;
    #1;
    check_eq("mid_wr_rise", mem_wr, 1);
    check_eq("mid_cs_rise", ram_cs, 1);
    check_eq("mid_db_release", mem_db, PROBE);
    check_eq("mid_busy", bus.busy, 0);
    probe_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_no_rdv", rd_cnt, 6);
    do_access(1'b0, 23'h5, 16'h0, 2'b11, 16'hA5C3);
    check_eq("post_rst_rdv_at", r_rdv_at, W + 1);
    check_eq("post_rst_strobe", r_cs_cnt, W);
    repeat (2) @(negedge clk);
    check_eq("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
